// File: rtl/core_pkg.sv
// Shared RV32 core widths and the word/select types used across the integer datapath.
package core_pkg;
    localparam int XLEN           = 32;
    localparam int REG_SELECT_LEN = 5;
    localparam int NUM_REGS       = 2 ** REG_SELECT_LEN;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_SELECT_LEN-1:0] reg_sel_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bits per architectural register; set on issue, cleared on write-back.
// Registered state, combinational next-state exported for same-edge read sampling; no backpressure.
module reg_scoreboard #(
    parameter int REG_SELECT_LEN = core_pkg::REG_SELECT_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reserve_en,
    input  logic [REG_SELECT_LEN-1:0]     reserve_register,
    input  logic                          write_en,
    input  logic [REG_SELECT_LEN-1:0]     output_register,
    output logic [2**REG_SELECT_LEN-1:0]  pending,
    output logic [2**REG_SELECT_LEN-1:0]  pending_next
);
    localparam int NUM_REGS = 2 ** REG_SELECT_LEN;

    logic [NUM_REGS-1:0] reserve_hot;
    logic [NUM_REGS-1:0] write_hot;

    // The reservation is OR-ed in after the clear so a same-edge reserve wins over the write-back.
    always_comb begin
        reserve_hot = '0;
        write_hot   = '0;
        if (reserve_en) reserve_hot[reserve_register] = 1'b1;
        if (write_en)   write_hot[output_register]    = 1'b1;
        pending_next    = reserve_hot | (pending & ~write_hot);
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end
endmodule

// File: rtl/reg_file.sv
// RV32 integer register file: 2 registered read ports with write bypass, 1 write port, pending scoreboard.
// Read latency 1 cycle; outputs hold while read_en is low; no backpressure.
module reg_file #(
    parameter int XLEN           = core_pkg::XLEN,
    parameter int REG_SELECT_LEN = core_pkg::REG_SELECT_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          read_en,
    input  logic [REG_SELECT_LEN-1:0]     register_1,
    input  logic [REG_SELECT_LEN-1:0]     register_2,
    output logic [XLEN-1:0]               register_data_1,
    output logic [XLEN-1:0]               register_data_2,
    output logic                          read_pending_1,
    output logic                          read_pending_2,
    input  logic                          reserve_en,
    input  logic [REG_SELECT_LEN-1:0]     reserve_register,
    input  logic                          write_en,
    input  logic [REG_SELECT_LEN-1:0]     output_register,
    input  logic [XLEN-1:0]               output_register_data,
    output logic [2**REG_SELECT_LEN-1:0]  pending_mask
);
    localparam int NUM_REGS = 2 ** REG_SELECT_LEN;

    // x0 has no storage; it is synthesised as a constant zero in the read mux.
    logic [XLEN-1:0]     regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] pending_next;
    logic [XLEN-1:0]     bypass_1;
    logic [XLEN-1:0]     bypass_2;

    reg_scoreboard #(
        .REG_SELECT_LEN (REG_SELECT_LEN)
    ) u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .reserve_en       (reserve_en),
        .reserve_register (reserve_register),
        .write_en         (write_en),
        .output_register  (output_register),
        .pending          (pending_mask),
        .pending_next     (pending_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (write_en && output_register != '0) begin
            regs[output_register] <= output_register_data;
        end
    end

    function automatic logic [XLEN-1:0] read_after_write(input logic [REG_SELECT_LEN-1:0] sel);
        logic [XLEN-1:0] value;
        value = '0;
        if (sel != '0) begin
            if (write_en && output_register == sel) value = output_register_data;
            else                                    value = regs[sel];
        end
        return value;
    endfunction

    always_comb begin
        bypass_1 = read_after_write(register_1);
        bypass_2 = read_after_write(register_2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            register_data_1 <= '0;
            register_data_2 <= '0;
            read_pending_1  <= 1'b0;
            read_pending_2  <= 1'b0;
        end else if (read_en) begin
            register_data_1 <= bypass_1;
            register_data_2 <= bypass_2;
            read_pending_1  <= pending_next[register_1];
            read_pending_2  <= pending_next[register_2];
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Randomised plus directed scoreboard bench for reg_file against an array-based architectural model.
module tb_reg_file;
    import core_pkg::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     read_en = 1'b0;
    reg_sel_t register_1 = '0, register_2 = '0;
    word_t    register_data_1, register_data_2;
    logic     read_pending_1, read_pending_2;
    logic     reserve_en = 1'b0;
    reg_sel_t reserve_register = '0;
    logic     write_en = 1'b0;
    reg_sel_t output_register = '0;
    word_t    output_register_data = '0;
    logic [NUM_REGS-1:0] pending_mask;

    reg_file dut (
        .clk                  (clk),
        .rst                  (rst),
        .read_en              (read_en),
        .register_1           (register_1),
        .register_2           (register_2),
        .register_data_1      (register_data_1),
        .register_data_2      (register_data_2),
        .read_pending_1       (read_pending_1),
        .read_pending_2       (read_pending_2),
        .reserve_en           (reserve_en),
        .reserve_register     (reserve_register),
        .write_en             (write_en),
        .output_register      (output_register),
        .output_register_data (output_register_data),
        .pending_mask         (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t               d1;
        word_t               d2;
        logic                p1;
        logic                p2;
        logic [NUM_REGS-1:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Architectural model: plain arrays, updated in program order (write, then reserve).
    word_t mem  [NUM_REGS];
    bit    pend [NUM_REGS];
    word_t hold_d1, hold_d2;
    bit    hold_p1, hold_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            mem[r]  = '0;
            pend[r] = 1'b0;
        end
        hold_d1 = '0; hold_d2 = '0; hold_p1 = 1'b0; hold_p2 = 1'b0;
    endtask

    task automatic cyc(input bit re, input int r1, input int r2,
                       input bit rv, input int rr,
                       input bit we, input int wr, input word_t wd);
        exp_t e;
        @(negedge clk);
        read_en              = re;
        register_1           = reg_sel_t'(r1);
        register_2           = reg_sel_t'(r2);
        reserve_en           = rv;
        reserve_register     = reg_sel_t'(rr);
        write_en             = we;
        output_register      = reg_sel_t'(wr);
        output_register_data = wd;
        if (we && wr != 0) mem[wr] = wd;
        if (we)            pend[wr] = 1'b0;
        if (rv && rr != 0) pend[rr] = 1'b1;
        if (re) begin
            hold_d1 = mem[r1]; hold_d2 = mem[r2];
            hold_p1 = pend[r1]; hold_p2 = pend[r2];
        end
        e.d1 = hold_d1; e.d2 = hold_d2; e.p1 = hold_p1; e.p2 = hold_p2;
        for (int r = 0; r < NUM_REGS; r++) e.mask[r] = pend[r];
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_1"}, register_data_1, 32'h0);
        check({tag, "_data_2"}, register_data_2, 32'h0);
        check({tag, "_pend_1"}, {31'h0, read_pending_1}, 32'h0);
        check({tag, "_pend_2"}, {31'h0, read_pending_2}, 32'h0);
        check({tag, "_mask"}, pending_mask, 32'h0);
    endtask

    // Monitor: outputs are flop-driven, so one expected entry exists per edge the driver issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_1", register_data_1, e.d1);
                check("data_2", register_data_2, e.d2);
                check("pend_1", {31'h0, read_pending_1}, {31'h0, e.p1});
                check("pend_2", {31'h0, read_pending_2}, {31'h0, e.p2});
                check("mask", pending_mask, e.mask);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c;
        word_t d;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Write/read and same-port-pair read of one register, then same-edge bypass.
        cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 3, 32'h1234_5678);
        cyc(1'b1, 3, 3, 1'b0, 0, 1'b0, 0, '0);
        cyc(1'b1, 4, 4, 1'b0, 0, 1'b1, 4, 32'hA5A5_A5A5);
        // x0: write and reserve are both dropped.
        cyc(1'b1, 0, 0, 1'b1, 0, 1'b1, 0, 32'hFFFF_FFFF);
        cyc(1'b1, 0, 3, 1'b0, 0, 1'b0, 0, '0);
        // Scoreboard lifecycle on x7.
        cyc(1'b1, 7, 0, 1'b1, 7, 1'b0, 0, '0);
        idle();
        cyc(1'b1, 7, 7, 1'b0, 0, 1'b1, 7, 32'h0000_0055);
        // Simultaneous reserve and write of x9 leaves it pending.
        cyc(1'b1, 9, 0, 1'b1, 9, 1'b1, 9, 32'h0BAD_F00D);
        cyc(1'b1, 9, 9, 1'b0, 0, 1'b0, 0, '0);
        cyc(1'b1, 9, 0, 1'b0, 0, 1'b1, 9, 32'h0000_0099);
        // Re-reserve an already pending register, then a plain write to a clear register.
        cyc(1'b0, 0, 0, 1'b1, 12, 1'b0, 0, '0);
        cyc(1'b1, 12, 13, 1'b1, 12, 1'b1, 13, 32'h1313_1313);
        // Hold: outputs freeze while read_en is low.
        cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 2, 32'h0000_0011);
        cyc(1'b1, 2, 2, 1'b0, 0, 1'b0, 0, '0);
        cyc(1'b0, 5, 9, 1'b0, 0, 1'b1, 2, 32'h0000_0022);
        idle();
        cyc(1'b1, 2, 0, 1'b0, 0, 1'b0, 0, '0);

        // Reset mid-run with x5 holding data and pending.
        cyc(1'b0, 0, 0, 1'b0, 0, 1'b1, 5, 32'hDEAD_BEEF);
        cyc(1'b1, 5, 5, 1'b1, 5, 1'b0, 0, '0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        model_reset();
        read_en = 1'b0; reserve_en = 1'b0; write_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 5, 7, 1'b0, 0, 1'b0, 0, '0);
        idle();

        // Random traffic, selects biased to a small window so collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            c = int'($urandom_range(0, 7));
            d = $urandom;
            cyc($urandom_range(0, 3) != 0, a, b,
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, c, d);
        end
        idle();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
